stream_fork_sel_reg: RTL and testbench

// Registered, selectable stream fork: accepts one input beat (data + destination mask) into a

---
 rtl/stream_fork_sel_reg.sv | 81 ++++++++
 tb/tb_stream_fork_sel_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fork_sel_reg.sv
// Registered, selectable stream fork.
// One input beat (payload + destination mask) is captured in a holding register
// and offered to every selected output until each of them has handshaked once.
// Beats accepted with an empty mask are consumed silently and counted.
module stream_fork_sel_reg #(
   parameter int unsigned N_OUP        = 2,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter bit          FALL_THROUGH = 1'b1,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [N_OUP-1:0]      sel_i,
   output logic [N_OUP-1:0]      valid_o,
   input  logic [N_OUP-1:0]      ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

   if (N_OUP < 1) begin : g_bad_n_oup
      $fatal(1, "stream_fork_sel_reg: N_OUP must be >= 1");
   end

   // pend_q bit i set: output i still owes a handshake for the held beat
   logic [N_OUP-1:0]      pend_q;
   logic [N_OUP-1:0]      pend_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  empty;
   logic                  last;
   logic                  in_hs;

   assign empty = (pend_q == '0);
   // every still-owed output completes in this cycle
   assign last  = ((pend_q & ~ready_i) == '0);

   // Input-side ready: fall-through version closes the beat in the same cycle
   // as the final output handshake; registered version waits for empty and
   // thereby keeps ready_i out of the ready_o timing path.
   if (FALL_THROUGH) begin : g_ready_ft
      assign ready_o = last;
   end else begin : g_ready_reg
      assign ready_o = empty;
   end

   assign in_hs = valid_i & ready_o;

   // Next pending mask: a new beat replaces the mask (same-cycle clears were
   // already final handshakes of the old beat), otherwise retire handshaken outputs.
   always_comb begin
      pend_d = pend_q & ~ready_i;
      if (in_hs) begin
         pend_d = sel_i;
      end
   end

   // Holding register, pending mask and saturating drop counter
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pend_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         if (in_hs) begin
            data_q <= data_i;
            if ((sel_i == '0) && (cnt_q != '1)) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign valid_o    = pend_q;
   assign data_o     = data_q;
   assign drop_cnt_o = cnt_q;

endmodule

// File: tb/tb_stream_fork_sel_reg.sv
// Bench for stream_fork_sel_reg: a fall-through 3-output instance and a
// registered 2-output instance, driven by a vector table, hand sequences and
// random traffic, compared with a beat-level reference model.
module tb_stream_fork_sel_reg;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // instance 0: N_OUP=3, FALL_THROUGH=1
   logic       v0, rdyo0;
   logic [7:0] d0, do0, cnt0;
   logic [2:0] s0, vo0, r0;
   // instance 1: N_OUP=2, FALL_THROUGH=0
   logic       v1, rdyo1;
   logic [7:0] d1, do1, cnt1;
   logic [1:0] s1, vo1, r1;

   stream_fork_sel_reg #(.N_OUP(3), .DATA_WIDTH(8), .FALL_THROUGH(1'b1), .CNT_WIDTH(8)) dut_ft (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .ready_o(rdyo0), .data_i(d0), .sel_i(s0),
      .valid_o(vo0), .ready_i(r0), .data_o(do0), .drop_cnt_o(cnt0));

   stream_fork_sel_reg #(.N_OUP(2), .DATA_WIDTH(8), .FALL_THROUGH(1'b0), .CNT_WIDTH(8)) dut_nf (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdyo1), .data_i(d1), .sel_i(s1),
      .valid_o(vo1), .ready_i(r1), .data_o(do1), .drop_cnt_o(cnt1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the current beat, which outputs it is addressed to,
   // which of those have already taken it, and how many empty-mask beats arrived.
   logic [7:0] m_data  [2];
   bit         m_dest  [2][3];
   bit         m_done  [2][3];
   int         m_drops [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_data[k]  = 8'h00;
         m_drops[k] = 0;
         for (int i = 0; i < 3; i++) begin
            m_dest[k][i] = 1'b0;
            m_done[k][i] = 1'b0;
         end
      end
   endtask

   // Compare instance k with the model, then advance the model by one clock.
   task automatic model_step(input int k);
      int  nk, ev, act_v, act_rdy, act_d, act_c, in_v, in_d, in_s, in_r;
      bit  ft, any_owed, owed_waiting, exp_rdy;
      nk = (k == 0) ? 3 : 2;
      ft = (k == 0);
      if (k == 0) begin
         act_v = int'(vo0); act_rdy = int'(rdyo0); act_d = int'(do0); act_c = int'(cnt0);
         in_v = int'(v0); in_d = int'(d0); in_s = int'(s0); in_r = int'(r0);
      end else begin
         act_v = int'(vo1); act_rdy = int'(rdyo1); act_d = int'(do1); act_c = int'(cnt1);
         in_v = int'(v1); in_d = int'(d1); in_s = int'(s1); in_r = int'(r1);
      end
      ev = 0;
      any_owed = 1'b0;
      owed_waiting = 1'b0;
      for (int i = 0; i < nk; i++) begin
         if (m_dest[k][i] && !m_done[k][i]) begin
            ev += (1 << i);
            any_owed = 1'b1;
            if (((in_r >> i) & 1) == 0) owed_waiting = 1'b1;
         end
      end
      exp_rdy = ft ? !owed_waiting : !any_owed;
      chk($sformatf("model_valid_o[%0d]", k), act_v, ev);
      chk($sformatf("model_ready_o[%0d]", k), act_rdy, int'(exp_rdy));
      chk($sformatf("model_data_o[%0d]", k), act_d, int'(m_data[k]));
      chk($sformatf("model_drop_cnt[%0d]", k), act_c, (m_drops[k] > 255) ? 255 : m_drops[k]);
      if (rst_n == 1'b0) begin
         m_data[k]  = 8'h00;
         m_drops[k] = 0;
         for (int i = 0; i < 3; i++) begin
            m_dest[k][i] = 1'b0;
            m_done[k][i] = 1'b0;
         end
      end else if (in_v != 0 && exp_rdy) begin
         m_data[k] = 8'(in_d);
         if (in_s == 0) m_drops[k]++;
         for (int i = 0; i < 3; i++) begin
            m_dest[k][i] = (i < nk) && (((in_s >> i) & 1) != 0);
            m_done[k][i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < nk; i++) begin
            if (m_dest[k][i] && ((in_r >> i) & 1) != 0) m_done[k][i] = 1'b1;
         end
      end
   endtask

   // One clock: inputs already driven; settle, check both instances, advance.
   task automatic step();
      #1;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic [2:0] sel;
      logic [2:0] rdy;
      logic [2:0] exp_valid;
      logic       exp_ready;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [11];

   initial begin
      // full-rate streaming, staggered completion, multicast subset
      vecs[0]  = '{1'b1, 8'hA5, 3'b111, 3'b111, 3'b000, 1'b1, 8'h00};
      vecs[1]  = '{1'b1, 8'h3C, 3'b111, 3'b111, 3'b111, 1'b1, 8'hA5};
      vecs[2]  = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b111, 1'b1, 8'h3C};
      vecs[3]  = '{1'b1, 8'h5A, 3'b111, 3'b001, 3'b000, 1'b1, 8'h3C};
      vecs[4]  = '{1'b1, 8'h77, 3'b101, 3'b001, 3'b111, 1'b0, 8'h5A};
      vecs[5]  = '{1'b1, 8'h77, 3'b101, 3'b010, 3'b110, 1'b0, 8'h5A};
      vecs[6]  = '{1'b1, 8'h77, 3'b101, 3'b100, 3'b100, 1'b1, 8'h5A};
      vecs[7]  = '{1'b0, 8'h00, 3'b000, 3'b010, 3'b101, 1'b0, 8'h77};
      vecs[8]  = '{1'b0, 8'h00, 3'b000, 3'b001, 3'b101, 1'b0, 8'h77};
      vecs[9]  = '{1'b0, 8'h00, 3'b000, 3'b110, 3'b100, 1'b1, 8'h77};
      vecs[10] = '{1'b0, 8'h00, 3'b000, 3'b000, 3'b000, 1'b1, 8'h77};

      rst_n = 1'b0;
      v0 = 1'b0; d0 = '0; s0 = '0; r0 = '0;
      v1 = 1'b0; d1 = '0; s1 = '0; r1 = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_ready_o", int'(rdyo0), 1);
      chk("reset_valid_o", int'(vo0), 0);
      chk("reset_data_o", int'(do0), 0);
      rst_n = 1'b1;

      // table-driven vectors on the fall-through instance
      for (int n = 0; n < 11; n++) begin
         v0 = vecs[n].valid; d0 = vecs[n].data; s0 = vecs[n].sel; r0 = vecs[n].rdy;
         #1;
         chk($sformatf("vec%0d_valid_o", n), int'(vo0), int'(vecs[n].exp_valid));
         chk($sformatf("vec%0d_ready_o", n), int'(rdyo0), int'(vecs[n].exp_ready));
         chk($sformatf("vec%0d_data_o", n), int'(do0), int'(vecs[n].exp_data));
         step();
      end
      v0 = 1'b0;

      // empty-mask beats saturate the drop counter and never raise valid_o
      s0 = 3'b000; r0 = 3'b000;
      for (int n = 0; n < 300; n++) begin
         v0 = 1'b1; d0 = 8'(n);
         #1;
         chk("drop_valid_o", int'(vo0), 0);
         step();
      end
      v0 = 1'b0;
      #1;
      chk("drop_cnt_sat", int'(cnt0), 255);

      // registered instance: ready_o alternates at one beat per two cycles
      v1 = 1'b1; s1 = 2'b11; r1 = 2'b11;
      for (int n = 0; n < 6; n++) begin
         d1 = 8'(8'h10 + n);
         #1;
         chk($sformatf("nf_alt%0d_ready_o", n), int'(rdyo1), (n % 2 == 0) ? 1 : 0);
         step();
      end
      v1 = 1'b0;
      step();
      // no path from ready_i to ready_o while empty
      r1 = 2'b00;
      #1;
      chk("nf_comb_ready_lo", int'(rdyo1), 1);
      r1 = 2'b11;
      #1;
      chk("nf_comb_ready_hi", int'(rdyo1), 1);

      // reset while a beat is partly delivered
      v1 = 1'b1; d1 = 8'hC3; s1 = 2'b11; r1 = 2'b01;
      step();
      v1 = 1'b0;
      step();
      chk("rst_mid_pending", int'(vo1), 2'b10);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_mid_valid_o", int'(vo1), 0);
      chk("rst_mid_drop", int'(cnt1), 0);
      chk("rst_mid_ready_o", int'(rdyo1), 1);
      v1 = 1'b1; d1 = 8'h4E; s1 = 2'b11; r1 = 2'b00;
      step();
      v1 = 1'b0;
      #1;
      chk("rst_after_valid_o", int'(vo1), 2'b11);
      chk("rst_after_data_o", int'(do1), 8'h4E);
      r1 = 2'b11;
      step();

      // random traffic on both instances
      for (int n = 0; n < 3000; n++) begin
         v0 = ($urandom_range(0, 9) < 7);
         d0 = 8'($urandom);
         s0 = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom);
         r0 = 3'($urandom);
         v1 = ($urandom_range(0, 9) < 7);
         d1 = 8'($urandom);
         s1 = 2'($urandom);
         r1 = 2'($urandom);
         if (n == 1500) rst_n = 1'b0;
         else rst_n = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
